hc_sr04_emulator: RTL
=====================

# hc_sr04_emulator

Synthesizable model of the HC-SR04 ultrasonic sensor: the responder end of the trig/echo protocol driven by our `hc_sr04` controller. It accepts a trigger pulse, checks its minimum width and waits the burst time. It then drives an echo pulse whose width encodes a programmable distance. It is used for on-board loopback and hardware-in-the-loop tests of the controller, with no physical sensor attached.

## Interface
- `CLK_HZ`, 100_000_000: clock frequency. Informational; all timing parameters are in cycles.
- `TRIG_MIN_CYC`, 1000: minimum accepted trig high time (10 µs).
- `BURST_CYC`, 20000: delay from trig fall to echo rise (8 × 40 kHz burst, 200 µs).
- `TICKS_PER_CM`, 5882: echo cycles per cm (58.82 µs/cm).
- `MAX_CM`, 400: largest valid distance.
- `TIMEOUT_CYC`, 3_800_000: echo width for a missing or invalid target (38 ms).
- `HOLDOFF_CYC`, 100_000: dead time after echo fall before a new trig is accepted.
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset. Asynchronous assert, active-low (0 = reset).
- `trig`, in, 1: trigger from the controller. Asynchronous.
- `distance_cm`, in, 9: target distance. Latched at trig fall.
- `no_echo`, in, 1: forces a timeout response. Latched at trig fall.
- `echo`, out, 1: echo pulse to the controller. Registered.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse in the cycle echo falls.
- `err_short_trig`, out, 1: one-cycle pulse when a trig pulse is rejected as too short.
- `state`, out, 3: current FSM state, for debug.

## Operation
- `trig` passes through a 2-flop synchronizer. Call the output `trig_s`. All protocol decisions use `trig_s` and its one-cycle-delayed copy.
- FSM states and encodings:
  - IDLE = 0: wait for a rising edge of `trig_s`, then go to TRIG_HI and start the counter at 1.
  - TRIG_HI = 1: count cycles while `trig_s` is high. On the falling edge:
    - if count ≥ `TRIG_MIN_CYC`: latch `distance_cm` and `no_echo`, compute the echo width W, go to BURST;
    - otherwise: pulse `err_short_trig` and return to IDLE.
  - BURST = 2: count `BURST_CYC` cycles, then go to ECHO.
  - ECHO = 3: `echo` = 1 for exactly W cycles, then go to HOLDOFF.
  - HOLDOFF = 4: count `HOLDOFF_CYC` cycles, then go to IDLE.
- Echo width W:
  - W = `distance_cm` × `TICKS_PER_CM`. Computed into a 22-bit register (400 × 5882 = 2,352,800 fits).
  - W = `TIMEOUT_CYC` if the latched `distance_cm` = 0, `distance_cm` > `MAX_CM`, or `no_echo` = 1.
  - The multiply may be registered, provided the BURST timing below is unchanged.
- One shared 22-bit down/up counter. It must not wrap in any state. A trig held high longer than 2^22 cycles saturates the count and is still accepted.
- Trig edges seen in BURST, ECHO or HOLDOFF are ignored.
- On entering IDLE with `trig_s` already high, no pulse is started. A low-to-high edge is required first.
- `distance_cm` changes after the latch point have no effect on the current measurement.

## Timing
- Reset values: `echo`, `busy`, `done` and `err_short_trig` = 0; `state` = IDLE; counter = 0.
- Reset mid-operation forces `echo` low asynchronously and drops any pending measurement.
- Latency from a `trig` pin change to the corresponding `trig_s` change: 2 clk edges.
- Let F = the first cycle in which `trig_s` = 0 after a valid high pulse.
  - `echo` rises at F + `BURST_CYC` (±1 cycle allowed; fixed per implementation).
  - `echo` stays high exactly W cycles.
- `done` and `err_short_trig` are each one cycle wide, registered, and never asserted together.
- `busy` rises the cycle after the accepted rising edge. It falls on the return to IDLE.
- Minimum period between accepted triggers: `TRIG_MIN_CYC` + `BURST_CYC` + W + `HOLDOFF_CYC`.

## Test plan
- 10 µs trig with `distance_cm` = 17: echo rises 200 µs after the trig fall and is high for 99,994 cycles; the controller's `distanceRAW` ≈ 99,994.
- `distance_cm` = 25, then 50, on successive triggers: echo widths of 147,050 and 294,100 cycles; `done` pulses once per measurement.
- 5 µs trig (500 cycles): no echo, one `err_short_trig` pulse, FSM back in IDLE, `busy` low.
- `distance_cm` = 0, then 401, then `no_echo` = 1: each gives an echo width of exactly 3,800,000 cycles.
- Second trig asserted during ECHO, and `distance_cm` changed mid-echo: echo width unchanged, no second echo, and no new measurement until a fresh trig edge after HOLDOFF.
- `rst` asserted 50,000 cycles into ECHO: `echo` goes low without waiting for a clk edge, `state` = IDLE, and a normal measurement succeeds after release.

Source files
------------

// File: rtl/hc_sr04_emulator.sv
// Purpose: responder end of the HC-SR04 trig/echo protocol; echo width encodes a programmable distance.
// Latency: echo rises BURST_CYC cycles after the first synchronized-low trig cycle, stays high W cycles.
// Backpressure: none; trig edges outside IDLE are ignored and HOLDOFF enforces a dead time.
module hc_sr04_emulator #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int TRIG_MIN_CYC = 1000,
  parameter int BURST_CYC    = 20000,
  parameter int TICKS_PER_CM = 5882,
  parameter int MAX_CM       = 400,
  parameter int TIMEOUT_CYC  = 3_800_000,
  parameter int HOLDOFF_CYC  = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig,
  input  logic [8:0] distance_cm,
  input  logic       no_echo,
  output logic       echo,
  output logic       busy,
  output logic       done,
  output logic       err_short_trig,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRIG_HI = 3'd1,
    BURST   = 3'd2,
    ECHO    = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  // BURST loads BURST_CYC-2 so that, with the cycle spent detecting the fall,
  // echo rises exactly BURST_CYC cycles after the first low trig_s cycle.
  localparam logic [21:0] TRIG_MIN   = 22'(TRIG_MIN_CYC);
  localparam logic [21:0] BURST_LOAD = 22'(BURST_CYC - 2);
  localparam logic [21:0] HOLD_LOAD  = 22'(HOLDOFF_CYC - 1);
  localparam logic [21:0] TICKS      = 22'(TICKS_PER_CM);
  localparam logic [21:0] MAX_D      = 22'(MAX_CM);
  localparam logic [21:0] TIMEOUT    = 22'(TIMEOUT_CYC);

  // Reject parameter sets the counter scheme cannot honour.
  if (BURST_CYC < 2 || HOLDOFF_CYC < 1 || TICKS_PER_CM < 1 || CLK_HZ <= 0) begin : g_param_check
    $error("hc_sr04_emulator: unsupported timing parameters");
  end

  state_t      st, st_nxt;
  logic [21:0] cnt, cnt_nxt;
  logic [21:0] width, width_nxt;
  logic        echo_nxt, done_nxt, err_nxt;
  logic        trig_m, trig_s, trig_d;
  logic        rise;
  logic [21:0] dist_w, w_calc;

  assign rise   = trig_s & ~trig_d;
  assign dist_w = 22'(distance_cm);
  assign w_calc = (no_echo || dist_w == 22'd0 || dist_w > MAX_D) ? TIMEOUT : dist_w * TICKS;

  assign state = st;
  assign busy  = (st != IDLE);

  // Two-flop synchronizer for the asynchronous trig pin plus a delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trig_m <= 1'b0;
      trig_s <= 1'b0;
      trig_d <= 1'b0;
    end else begin
      trig_m <= trig;
      trig_s <= trig_m;
      trig_d <= trig_s;
    end
  end

  // State, shared counter, latched width and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st             <= IDLE;
      cnt            <= '0;
      width          <= '0;
      echo           <= 1'b0;
      done           <= 1'b0;
      err_short_trig <= 1'b0;
    end else begin
      st             <= st_nxt;
      cnt            <= cnt_nxt;
      width          <= width_nxt;
      echo           <= echo_nxt;
      done           <= done_nxt;
      err_short_trig <= err_nxt;
    end
  end

  // Next-state logic; the counter never wraps (saturates up, stops at zero down).
  always_comb begin
    st_nxt    = st;
    cnt_nxt   = cnt;
    width_nxt = width;
    echo_nxt  = echo;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    unique case (st)
      IDLE: begin
        if (rise) begin
          st_nxt  = TRIG_HI;
          cnt_nxt = 22'd1;
        end
      end
      TRIG_HI: begin
        if (trig_s) begin
          if (cnt != '1) cnt_nxt = cnt + 22'd1;
        end else if (cnt >= TRIG_MIN) begin
          st_nxt    = BURST;
          cnt_nxt   = BURST_LOAD;
          width_nxt = w_calc;
        end else begin
          st_nxt  = IDLE;
          cnt_nxt = '0;
          err_nxt = 1'b1;
        end
      end
      BURST: begin
        if (cnt == 22'd0) begin
          st_nxt   = ECHO;
          cnt_nxt  = width - 22'd1;
          echo_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - 22'd1;
        end
      end
      ECHO: begin
        if (cnt == 22'd0) begin
          st_nxt   = HOLDOFF;
          cnt_nxt  = HOLD_LOAD;
          echo_nxt = 1'b0;
          done_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - 22'd1;
        end
      end
      HOLDOFF: begin
        if (cnt == 22'd0) begin
          st_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 22'd1;
        end
      end
      default: begin
        st_nxt   = IDLE;
        cnt_nxt  = '0;
        echo_nxt = 1'b0;
      end
    endcase
  end

endmodule
